addr_decoder_n: RTL and testbench
=================================

Name: addr_decoder_n

Overview:
Parametrised serial address decoder for the shared serial bus. It deserialises an ADDR_W-bit address from the 1-bit bus stream while bus_mode=0 and matches it against NUM_TARGETS base/mask windows. It then holds a one-hot target-valid vector and its encoded select until the bus releases the target. Compared with the fixed 3-target decoder, it adds configurable width, target count and bit order, a gap timeout, an unmapped-address error pulse and a captured-address output.

Parameters:
ADDR_W, 16, address width in bits (2..32)
NUM_TARGETS, 3, number of targets (1..8)
MSB_FIRST, 0, 0 = first serial bit is addr[0]; 1 = first serial bit is addr[ADDR_W-1]
TARGET_BASE, {16'h8000,16'h4000,16'h0000}, packed NUM_TARGETS*ADDR_W base addresses; target i occupies slice i
TARGET_MASK, {16'hF000,16'hF000,16'hF800}, packed compare masks; a set bit means the bit is compared
GAP_TIMEOUT, 0, number of idle valid-low cycles tolerated mid-address before abort; 0 = abort on the first low cycle

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
bus_data_in  input  1  serial address/data bit
bus_data_in_valid  input  1  bit strobe
bus_mode  input  1  1 = data phase, 0 = address phase
release_valids  input  NUM_TARGETS  one-hot release strobes from the bus
target_valid  output  NUM_TARGETS  held one-hot target select
sel  output  SEL_W = max(1,$clog2(NUM_TARGETS))  index of the asserted target; 0 when none is asserted
addr_out  output  ADDR_W  last fully captured address
decode_err  output  1  one-cycle pulse when an address matches no target
busy  output  1  high in any state other than IDLE

Behaviour:
- All state is registered. rst is sampled only at the rising edge of clk.
- Reset values:
  - state = IDLE
  - target_valid = 0, sel = 0, addr_out = 0, decode_err = 0
  - bit counter = 0, gap counter = 0, shift register = 0
- A bit is accepted on an edge where bus_mode=0, bus_data_in_valid=1 and the state is IDLE or SHIFT.
- Shifting:
  - MSB_FIRST=0: shift = {bit, shift[ADDR_W-1:1]}.
  - MSB_FIRST=1: shift = {shift[ADDR_W-2:0], bit}.
- Match rule: target i matches when (addr & MASK_i) == (BASE_i & MASK_i). When several targets match, the lowest index wins.
- States:
  - IDLE: the first accepted bit moves to SHIFT with count=1. Bits with bus_mode=1 are ignored.
  - SHIFT:
    - Each accepted bit increments the count.
    - On the edge that accepts bit ADDR_W (count==ADDR_W-1), the full address is latched into addr_out, the decode result is registered as pending, and the state moves to LOAD.
    - A valid-low cycle increments the gap counter. When the gap counter would exceed GAP_TIMEOUT, the block returns to IDLE and clears the count, shift register and gap counter.
    - An accepted bit resets the gap counter.
    - bus_mode=1 in SHIFT aborts to IDLE with the same clearing.
  - LOAD (exactly one cycle):
    - Match: target_valid = pending one-hot and sel = its index at this edge. Next state is HOLD.
    - No match: decode_err=1 for this single edge, target_valid stays 0, next state is IDLE.
    - Bus input is ignored.
  - HOLD:
    - Address bits are ignored.
    - When release_valids & target_valid != 0, target_valid clears at that edge, sel=0, and the state moves to IDLE.
    - Release strobes for non-held targets are ignored.
- Simultaneous events:
  - A release presented on the LOAD edge applies to the newly loaded vector in the same edge. Net result: target_valid stays 0 and the state goes to IDLE, with no error pulse.
  - If rst is asserted in any state, reset wins.
- Latency: the last address bit is accepted at edge t; target_valid/sel (or decode_err) are visible after edge t+1.
- A new address can begin on the cycle after the block returns to IDLE.
- addr_out holds its value until the next full capture, including across aborts.

Test Plan:
- Defaults, LSB-first 16'h0123 streamed over 16 consecutive valid cycles -> after 1 extra edge target_valid=3'b001, sel=0, busy=1; release_valids=3'b001 -> next edge target_valid=0, busy=0.
- Defaults, 16'h8ABC -> target_valid=3'b100, sel=2, addr_out=16'h8ABC; release_valids=3'b010 ignored, hold persists; 3'b100 releases.
- Defaults, 16'hC000 -> decode_err high exactly one cycle, target_valid=0, then 16'h4001 decodes to target_valid=3'b010, sel=1.
- GAP_TIMEOUT=2, 8 bits then valid low 2 cycles then 8 bits of 16'h4000 -> decodes 3'b010. Same stimulus with a 3-cycle gap -> abort, no decode, and the following 16 bits decode fresh.
- MSB_FIRST=1, ADDR_W=8, NUM_TARGETS=4, address 8'hA5 against the matching base -> correct one-hot. Release on the LOAD edge -> target_valid never asserts, no decode_err.
- rst asserted mid-SHIFT at bit 9 and again mid-HOLD -> all outputs 0 next edge, state IDLE; a subsequent full address decodes normally.

Source files
------------

// File: rtl/addr_decoder_n.sv
// Purpose : deserialise an ADDR_W-bit address from the serial bus and decode it against base/mask windows.
// Latency : target_valid/sel (or decode_err) visible one edge after the edge accepting the last address bit.
// Backpress: none; the serial stream is not throttled, and bits arriving outside IDLE/SHIFT are dropped.
// Ports   : clk/rst (sync, active-high); bus_data_in/bus_data_in_valid/bus_mode serial input;
//           release_valids one-hot release; target_valid/sel held select; addr_out last capture;
//           decode_err one-cycle unmapped pulse; busy = not IDLE.
module addr_decoder_n #(
   parameter int                              ADDR_W      = 16,
   parameter int                              NUM_TARGETS = 3,
   parameter bit                              MSB_FIRST   = 1'b0,
   parameter logic [NUM_TARGETS*ADDR_W-1:0]   TARGET_BASE = {16'h8000, 16'h4000, 16'h0000},
   parameter logic [NUM_TARGETS*ADDR_W-1:0]   TARGET_MASK = {16'hF000, 16'hF000, 16'hF800},
   parameter int                              GAP_TIMEOUT = 0,
   localparam int                             SEL_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bus_data_in,
   input  logic                   bus_data_in_valid,
   input  logic                   bus_mode,
   input  logic [NUM_TARGETS-1:0] release_valids,
   output logic [NUM_TARGETS-1:0] target_valid,
   output logic [SEL_W-1:0]       sel,
   output logic [ADDR_W-1:0]      addr_out,
   output logic                   decode_err,
   output logic                   busy
);

   localparam int               CNT_W    = $clog2(ADDR_W + 1);
   localparam int               GAP_W    = $clog2(GAP_TIMEOUT + 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADDR_W - 1);
   localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_TIMEOUT);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD, HOLD} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [ADDR_W-1:0]      shift_q, shift_d, shift_nxt;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   pend_hit_q, pend_hit_d;
   logic [NUM_TARGETS-1:0] pend_oh_q, pend_oh_d;
   logic [SEL_W-1:0]       pend_sel_q, pend_sel_d;
   logic [NUM_TARGETS-1:0] tv_q, tv_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic                   err_q, err_d;
   logic                   accept;
   logic                   hit;
   logic [NUM_TARGETS-1:0] hit_oh;
   logic [SEL_W-1:0]       hit_sel;

   assign accept = !bus_mode && bus_data_in_valid && ((state_q == IDLE) || (state_q == SHIFT));

   if (MSB_FIRST) begin : g_msb
      assign shift_nxt = {shift_q[ADDR_W-2:0], bus_data_in};
   end else begin : g_lsb
      assign shift_nxt = {bus_data_in, shift_q[ADDR_W-1:1]};
   end

   // Decode the address as it will look after this bit is shifted in, so the
   // result can be registered on the same edge as the capture. Scanning from
   // the top index down lets the lowest matching index overwrite the others.
   always_comb begin
      hit     = 1'b0;
      hit_oh  = '0;
      hit_sel = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
         if ((shift_nxt & TARGET_MASK[i*ADDR_W +: ADDR_W]) ==
             (TARGET_BASE[i*ADDR_W +: ADDR_W] & TARGET_MASK[i*ADDR_W +: ADDR_W])) begin
            hit     = 1'b1;
            hit_oh  = NUM_TARGETS'(1) << i;
            hit_sel = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      pend_hit_d = pend_hit_q;
      pend_oh_d  = pend_oh_q;
      pend_sel_d = pend_sel_q;
      tv_d       = tv_q;
      sel_d      = sel_q;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = shift_nxt;
               cnt_d   = CNT_W'(1);
               gap_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (bus_mode) begin
               state_d = IDLE;
               cnt_d   = '0;
               gap_d   = '0;
               shift_d = '0;
            end else if (bus_data_in_valid) begin
               gap_d   = '0;
               shift_d = shift_nxt;
               if (cnt_q == LAST_CNT) begin
                  addr_d     = shift_nxt;
                  pend_hit_d = hit;
                  pend_oh_d  = hit_oh;
                  pend_sel_d = hit_sel;
                  cnt_d      = '0;
                  state_d    = LOAD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (gap_q == GAP_MAX) begin
               // One more idle cycle would exceed the tolerated gap.
               state_d = IDLE;
               cnt_d   = '0;
               gap_d   = '0;
               shift_d = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         LOAD: begin
            if (!pend_hit_q) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if ((release_valids & pend_oh_q) != '0) begin
               // Release coincides with the load: the select never becomes visible.
               state_d = IDLE;
            end else begin
               tv_d    = pend_oh_q;
               sel_d   = pend_sel_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if ((release_valids & tv_q) != '0) begin
               tv_d    = '0;
               sel_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         pend_hit_q <= 1'b0;
         pend_oh_q  <= '0;
         pend_sel_q <= '0;
         tv_q       <= '0;
         sel_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         pend_hit_q <= pend_hit_d;
         pend_oh_q  <= pend_oh_d;
         pend_sel_q <= pend_sel_d;
         tv_q       <= tv_d;
         sel_q      <= sel_d;
         err_q      <= err_d;
      end
   end

   assign target_valid = tv_q;
   assign sel          = sel_q;
   assign addr_out     = addr_q;
   assign decode_err   = err_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_addr_decoder_n.sv
// Purpose : directed self-checking bench for addr_decoder_n in three configurations.
// Latency : checks sample #1 after each rising edge; inputs change at the same point.
// Backpress: not applicable; the serial stream is driven continuously.
module tb_addr_decoder_n;

   logic       clk = 1'b0;
   logic       rst;
   logic       bus_data_in;
   logic       bus_data_in_valid;
   logic       bus_mode;
   logic [2:0] rel3;
   logic [3:0] rel4;

   logic [2:0]  d_tv, g_tv;
   logic [1:0]  d_sel, g_sel;
   logic [15:0] d_addr, g_addr;
   logic        d_err, g_err, d_busy, g_busy;
   logic [3:0]  m_tv;
   logic [1:0]  m_sel;
   logic [7:0]  m_addr;
   logic        m_err, m_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Default configuration.
   addr_decoder_n u_d (
      .clk(clk), .rst(rst), .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
      .bus_mode(bus_mode), .release_valids(rel3), .target_valid(d_tv), .sel(d_sel),
      .addr_out(d_addr), .decode_err(d_err), .busy(d_busy)
   );

   // Two idle cycles tolerated mid-address.
   addr_decoder_n #(.GAP_TIMEOUT(2)) u_g (
      .clk(clk), .rst(rst), .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
      .bus_mode(bus_mode), .release_valids(rel3), .target_valid(g_tv), .sel(g_sel),
      .addr_out(g_addr), .decode_err(g_err), .busy(g_busy)
   );

   // 8-bit MSB-first, four targets; A5 matches both t2 and t3 so t2 must win.
   addr_decoder_n #(
      .ADDR_W(8), .NUM_TARGETS(4), .MSB_FIRST(1'b1),
      .TARGET_BASE({8'hA5, 8'hA0, 8'h10, 8'h00}),
      .TARGET_MASK({8'hFF, 8'hF0, 8'hF0, 8'hF0})
   ) u_m (
      .clk(clk), .rst(rst), .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
      .bus_mode(bus_mode), .release_valids(rel4), .target_valid(m_tv), .sel(m_sel),
      .addr_out(m_addr), .decode_err(m_err), .busy(m_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Send serial positions [from,to) of address a (width w) in the chosen bit order.
   task automatic stream(input logic [31:0] a, input int w, input bit msb, input int from, input int to);
      for (int k = from; k < to; k++) begin
         bus_data_in       = msb ? a[w-1-k] : a[k];
         bus_data_in_valid = 1'b1;
         tick();
      end
      bus_data_in_valid = 1'b0;
      bus_data_in       = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus_data_in = 1'b0; bus_data_in_valid = 1'b0; bus_mode = 1'b0;
      rel3 = '0; rel4 = '0;
      do_reset();

      chk("rst_tv",   32'(d_tv),   32'h0);
      chk("rst_sel",  32'(d_sel),  32'h0);
      chk("rst_addr", 32'(d_addr), 32'h0);
      chk("rst_err",  32'(d_err),  32'h0);
      chk("rst_busy", 32'(d_busy), 32'h0);

      // 0x0123 -> target 0, one edge after the last bit.
      stream(32'h0123, 16, 1'b0, 0, 16);
      chk("a_load_tv",   32'(d_tv),   32'h0);
      chk("a_load_busy", 32'(d_busy), 32'h1);
      tick();
      chk("a_tv",   32'(d_tv),   32'h1);
      chk("a_sel",  32'(d_sel),  32'h0);
      chk("a_busy", 32'(d_busy), 32'h1);
      chk("a_addr", 32'(d_addr), 32'h0123);
      rel3 = 3'b001; tick(); rel3 = '0;
      chk("a_rel_tv",   32'(d_tv),   32'h0);
      chk("a_rel_busy", 32'(d_busy), 32'h0);

      // 0x8ABC -> target 2; a release for target 1 is ignored.
      stream(32'h8ABC, 16, 1'b0, 0, 16);
      tick();
      chk("b_tv",   32'(d_tv),   32'h4);
      chk("b_sel",  32'(d_sel),  32'h2);
      chk("b_addr", 32'(d_addr), 32'h8ABC);
      rel3 = 3'b010; tick(); rel3 = '0;
      chk("b_ign_tv",   32'(d_tv),   32'h4);
      chk("b_ign_busy", 32'(d_busy), 32'h1);
      rel3 = 3'b100; tick(); rel3 = '0;
      chk("b_rel_tv",  32'(d_tv),  32'h0);
      chk("b_rel_sel", 32'(d_sel), 32'h0);

      // 0xC000 is unmapped -> single-cycle error, then 0x4001 -> target 1.
      stream(32'hC000, 16, 1'b0, 0, 16);
      chk("c_err_early", 32'(d_err), 32'h0);
      tick();
      chk("c_err",  32'(d_err),  32'h1);
      chk("c_tv",   32'(d_tv),   32'h0);
      chk("c_busy", 32'(d_busy), 32'h0);
      chk("c_addr", 32'(d_addr), 32'hC000);
      tick();
      chk("c_err_drop", 32'(d_err), 32'h0);
      stream(32'h4001, 16, 1'b0, 0, 16);
      tick();
      chk("c2_tv",  32'(d_tv),  32'h2);
      chk("c2_sel", 32'(d_sel), 32'h1);
      rel3 = 3'b010; tick(); rel3 = '0;

      // Gap tolerance on the GAP_TIMEOUT=2 instance.
      do_reset();
      stream(32'h4000, 16, 1'b0, 0, 8);
      tick(); tick();
      stream(32'h4000, 16, 1'b0, 8, 16);
      tick();
      chk("g2_tv",  32'(g_tv),  32'h2);
      chk("g2_sel", 32'(g_sel), 32'h1);
      rel3 = 3'b010; tick(); rel3 = '0;
      chk("g2_rel_busy", 32'(g_busy), 32'h0);
      stream(32'h4000, 16, 1'b0, 0, 8);
      tick(); tick(); tick();
      chk("g3_abort_busy", 32'(g_busy), 32'h0);
      // The second half now starts a fresh address and must not complete one.
      stream(32'h4000, 16, 1'b0, 8, 16);
      tick();
      chk("g3_tv",   32'(g_tv),   32'h0);
      chk("g3_err",  32'(g_err),  32'h0);
      chk("g3_busy", 32'(g_busy), 32'h1);
      tick(); tick();
      chk("g3_idle", 32'(g_busy), 32'h0);
      chk("g3_addr_held", 32'(g_addr), 32'h4000);
      stream(32'h8001, 16, 1'b0, 0, 16);
      tick();
      chk("g4_tv",   32'(g_tv),   32'h4);
      chk("g4_sel",  32'(g_sel),  32'h2);
      chk("g4_addr", 32'(g_addr), 32'h8001);
      rel3 = 3'b100; tick(); rel3 = '0;

      // MSB-first 8-bit instance.
      do_reset();
      stream(32'hA5, 8, 1'b1, 0, 8);
      tick();
      chk("m_tv",   32'(m_tv),   32'h4);
      chk("m_sel",  32'(m_sel),  32'h2);
      chk("m_addr", 32'(m_addr), 32'hA5);
      rel4 = 4'b0100; tick(); rel4 = '0;
      chk("m_rel_tv", 32'(m_tv), 32'h0);
      stream(32'h1F, 8, 1'b1, 0, 8);
      tick();
      chk("m_order_tv",  32'(m_tv),  32'h2);
      chk("m_order_sel", 32'(m_sel), 32'h1);
      chk("m_order_addr", 32'(m_addr), 32'h1F);
      rel4 = 4'b0010; tick(); rel4 = '0;
      // Release presented on the LOAD edge.
      stream(32'hA5, 8, 1'b1, 0, 8);
      rel4 = 4'b0100; tick(); rel4 = '0;
      chk("m_ld_tv",   32'(m_tv),   32'h0);
      chk("m_ld_err",  32'(m_err),  32'h0);
      chk("m_ld_busy", 32'(m_busy), 32'h0);
      tick();
      chk("m_ld_tv2", 32'(m_tv), 32'h0);

      // Reset mid-HOLD and mid-SHIFT, bus_mode abort, then a clean decode.
      do_reset();
      stream(32'h8ABC, 16, 1'b0, 0, 16);
      tick();
      chk("r_hold_tv", 32'(d_tv), 32'h4);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("r_hold_tv0",   32'(d_tv),   32'h0);
      chk("r_hold_sel0",  32'(d_sel),  32'h0);
      chk("r_hold_addr0", 32'(d_addr), 32'h0);
      chk("r_hold_busy0", 32'(d_busy), 32'h0);
      stream(32'h4001, 16, 1'b0, 0, 9);
      chk("r_shift_busy", 32'(d_busy), 32'h1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("r_shift_busy0", 32'(d_busy), 32'h0);
      chk("r_shift_err0",  32'(d_err),  32'h0);
      stream(32'h0123, 16, 1'b0, 0, 5);
      bus_mode = 1'b1; bus_data_in_valid = 1'b1; tick();
      bus_mode = 1'b0; bus_data_in_valid = 1'b0;
      chk("mode_abort_busy", 32'(d_busy), 32'h0);
      stream(32'h0123, 16, 1'b0, 0, 16);
      tick();
      chk("r_after_tv",   32'(d_tv),   32'h1);
      chk("r_after_sel",  32'(d_sel),  32'h0);
      chk("r_after_addr", 32'(d_addr), 32'h0123);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
